// File: rtl/pipe_reg_w.sv
// pipe_reg_w: M-to-W pipeline register with write-back result selection,
// load data extraction and a retired-instruction counter.
// Optional feature: define PIPE_REG_W_SUBWORD_LOAD_EN to enable byte and
// halfword load extraction (lbu/lb/lhu/lh); otherwise memory data passes
// through as the raw word and LoadTypeM is ignored.
module pipe_reg_w (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallW,
  input  logic        FlushW,
  input  logic        RegWriteM,
  input  logic [4:0]  WriteRegM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] ReadDataM,
  input  logic [2:0]  LoadTypeM,
  input  logic [31:0] PCM,
  output logic        RegWriteW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ResultW,
  output logic [31:0] PCW,
  output logic        ValidW,
  output logic [31:0] RetireCnt
);

  logic        memtoRegQ;
  logic [31:0] aluOutQ;
  logic [31:0] readDataQ;
  logic [31:0] loadData;
  logic [31:0] retireCnt;

`ifdef PIPE_REG_W_SUBWORD_LOAD_EN
  typedef enum logic [2:0] {
    LoadWord  = 3'd0,
    LoadByteU = 3'd1,
    LoadByte  = 3'd2,
    LoadHalfU = 3'd3,
    LoadHalf  = 3'd4
  } loadType_e;

  logic [2:0]  loadTypeQ;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
`else
  logic unusedLoadType;
  assign unusedLoadType = ^LoadTypeM;
`endif

  // W-stage registers: reset clears, flush loads a bubble, stall holds
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      WriteRegW <= 5'd0;
      PCW       <= 32'd0;
      ValidW    <= 1'b0;
      memtoRegQ <= 1'b0;
      aluOutQ   <= 32'd0;
      readDataQ <= 32'd0;
`ifdef PIPE_REG_W_SUBWORD_LOAD_EN
      loadTypeQ <= 3'd0;
`endif
    end else if (FlushW) begin
      RegWriteW <= 1'b0;
      WriteRegW <= 5'd0;
      PCW       <= 32'd0;
      ValidW    <= 1'b0;
      memtoRegQ <= 1'b0;
      aluOutQ   <= 32'd0;
      readDataQ <= 32'd0;
`ifdef PIPE_REG_W_SUBWORD_LOAD_EN
      loadTypeQ <= 3'd0;
`endif
    end else if (!StallW) begin
      RegWriteW <= RegWriteM && (WriteRegM != 5'd0);
      WriteRegW <= WriteRegM;
      PCW       <= PCM;
      ValidW    <= 1'b1;
      memtoRegQ <= MemtoRegM;
      aluOutQ   <= ALUOutM;
      readDataQ <= ReadDataM;
`ifdef PIPE_REG_W_SUBWORD_LOAD_EN
      loadTypeQ <= LoadTypeM;
`endif
    end
  end

  // Retire counter: the W instruction leaves on any unstalled edge, including a flush edge
  always_ff @(posedge clk) begin
    if (reset) begin
      retireCnt <= 32'd0;
    end else if (ValidW && !StallW) begin
      retireCnt <= retireCnt + 32'd1;
    end
  end

  assign RetireCnt = retireCnt;

  // Load data extraction from the registered word, little-endian lanes
  always_comb begin
    loadData = readDataQ;
`ifdef PIPE_REG_W_SUBWORD_LOAD_EN
    byteSel  = readDataQ[7:0];
    halfSel  = aluOutQ[1] ? readDataQ[31:16] : readDataQ[15:0];
    case (aluOutQ[1:0])
      2'd0:    byteSel = readDataQ[7:0];
      2'd1:    byteSel = readDataQ[15:8];
      2'd2:    byteSel = readDataQ[23:16];
      default: byteSel = readDataQ[31:24];
    endcase
    case (loadTypeQ)
      LoadByteU: loadData = {24'd0, byteSel};
      LoadByte:  loadData = {{24{byteSel[7]}}, byteSel};
      LoadHalfU: loadData = {16'd0, halfSel};
      LoadHalf:  loadData = {{16{halfSel[15]}}, halfSel};
      default:   loadData = readDataQ;
    endcase
`endif
  end

  assign ResultW = memtoRegQ ? loadData : aluOutQ;

endmodule

// File: tb/tb_pipe_reg_w.sv
// tb_pipe_reg_w: directed-vector scoreboard bench for pipe_reg_w.
// Build with PIPE_REG_W_SUBWORD_LOAD_EN defined to check sub-word loads.
module tb_pipe_reg_w;

  logic        clk;
  logic        reset;
  logic        StallW;
  logic        FlushW;
  logic        RegWriteM;
  logic [4:0]  WriteRegM;
  logic        MemtoRegM;
  logic [31:0] ALUOutM;
  logic [31:0] ReadDataM;
  logic [2:0]  LoadTypeM;
  logic [31:0] PCM;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic [31:0] PCW;
  logic        ValidW;
  logic [31:0] RetireCnt;

`ifdef PIPE_REG_W_SUBWORD_LOAD_EN
  localparam bit SubWord = 1'b1;
`else
  localparam bit SubWord = 1'b0;
`endif

  localparam logic [31:0] MemWord = 32'h80F0A0B0;

  typedef struct {
    int          cycle;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] result;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] retire;
    string       name;
  } expect_t;

  expect_t expQ[$];
  expect_t monEntry;
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;

  pipe_reg_w dut (
    .clk       (clk),
    .reset     (reset),
    .StallW    (StallW),
    .FlushW    (FlushW),
    .RegWriteM (RegWriteM),
    .WriteRegM (WriteRegM),
    .MemtoRegM (MemtoRegM),
    .ALUOutM   (ALUOutM),
    .ReadDataM (ReadDataM),
    .LoadTypeM (LoadTypeM),
    .PCM       (PCM),
    .RegWriteW (RegWriteW),
    .WriteRegW (WriteRegW),
    .ResultW   (ResultW),
    .PCW       (PCW),
    .ValidW    (ValidW),
    .RetireCnt (RetireCnt)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to tag when each expected response is due
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Compare one scoreboard entry against the current W-stage outputs
  task automatic checkOutput(input expect_t e);
    checks++;
    if (RegWriteW !== e.regWrite || WriteRegW !== e.writeReg || ResultW !== e.result ||
        PCW !== e.pc || ValidW !== e.valid || RetireCnt !== e.retire) begin
      errors++;
      $display("[TB] FAIL %s: got rw=%0b wr=%0d res=%h pc=%h v=%0b cnt=%h, want rw=%0b wr=%0d res=%h pc=%h v=%0b cnt=%h",
               e.name, RegWriteW, WriteRegW, ResultW, PCW, ValidW, RetireCnt,
               e.regWrite, e.writeReg, e.result, e.pc, e.valid, e.retire);
    end
  endtask

  // Monitor: pop every expectation that falls due on this cycle and check it
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cycle <= cyc) begin
      monEntry = expQ.pop_front();
      if (monEntry.cycle < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: response missed, due cycle %0d, now %0d", monEntry.name, monEntry.cycle, cyc);
      end else begin
        checkOutput(monEntry);
      end
    end
  end

  // Drive one set of inputs for exactly one sampling edge and queue its expected W state
  task automatic applyStimulus(input string name, input logic rst, input logic stall, input logic flush,
                               input logic rw, input logic [4:0] wr, input logic mtr,
                               input logic [31:0] alu, input logic [31:0] rd, input logic [2:0] lt,
                               input logic [31:0] pc, input logic eRw, input logic [4:0] eWr,
                               input logic [31:0] eRes, input logic [31:0] ePc, input logic eValid,
                               input logic [31:0] eRetire, input bit presetRetire);
    expect_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    StallW    = stall;
    FlushW    = flush;
    RegWriteM = rw;
    WriteRegM = wr;
    MemtoRegM = mtr;
    ALUOutM   = alu;
    ReadDataM = rd;
    LoadTypeM = lt;
    PCM       = pc;
    e.cycle    = cyc + 1;
    e.regWrite = eRw;
    e.writeReg = eWr;
    e.result   = eRes;
    e.pc       = ePc;
    e.valid    = eValid;
    e.retire   = eRetire;
    e.name     = name;
    expQ.push_back(e);
    if (presetRetire) begin
      @(negedge clk);
      #1;
      force dut.retireCnt = 32'hFFFFFFFF;
      #1;
      release dut.retireCnt;
    end
  endtask

  initial begin
    reset     = 1'b1;
    StallW    = 1'b0;
    FlushW    = 1'b0;
    RegWriteM = 1'b0;
    WriteRegM = 5'd0;
    MemtoRegM = 1'b0;
    ALUOutM   = 32'd0;
    ReadDataM = 32'd0;
    LoadTypeM = 3'd0;
    PCM       = 32'd0;

    // Reset with random M-stage inputs
    applyStimulus("reset0", 1, 0, 0, 1, 5'($urandom), 1, $urandom, $urandom, 3'($urandom), $urandom,
                  0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    applyStimulus("reset1", 1, 0, 0, 1, 5'($urandom), 0, $urandom, $urandom, 3'($urandom), $urandom,
                  0, 0, 32'h0, 32'h0, 0, 32'h0, 0);

    // Basic ALU write-back and the $0 suppression
    applyStimulus("aluWrite", 0, 0, 0, 1, 5, 0, 32'h12345678, 32'hAAAA5555, 0, 32'h100,
                  1, 5, 32'h12345678, 32'h100, 1, 32'd0, 0);
    applyStimulus("reg0Write", 0, 0, 0, 1, 0, 0, 32'h11111111, 32'h0, 0, 32'h104,
                  0, 0, 32'h11111111, 32'h104, 1, 32'd1, 0);

    // Load extraction from the same memory word
    applyStimulus("lbByte3", 0, 0, 0, 1, 7, 1, 32'h2003, MemWord, 3'd2, 32'h108,
                  1, 7, SubWord ? 32'hFFFFFF80 : MemWord, 32'h108, 1, 32'd2, 0);
    applyStimulus("lbuByte3", 0, 0, 0, 1, 7, 1, 32'h2003, MemWord, 3'd1, 32'h10C,
                  1, 7, SubWord ? 32'h00000080 : MemWord, 32'h10C, 1, 32'd3, 0);
    applyStimulus("lhHalf0", 0, 0, 0, 1, 7, 1, 32'h2000, MemWord, 3'd4, 32'h110,
                  1, 7, SubWord ? 32'hFFFFA0B0 : MemWord, 32'h110, 1, 32'd4, 0);
    applyStimulus("lhuHalf1", 0, 0, 0, 1, 7, 1, 32'h2002, MemWord, 3'd3, 32'h114,
                  1, 7, SubWord ? 32'h000080F0 : MemWord, 32'h114, 1, 32'd5, 0);
    applyStimulus("lbByte1", 0, 0, 0, 1, 7, 1, 32'h2001, MemWord, 3'd2, 32'h118,
                  1, 7, SubWord ? 32'hFFFFFFA0 : MemWord, 32'h118, 1, 32'd6, 0);
    applyStimulus("lwWord", 0, 0, 0, 1, 7, 1, 32'h2000, MemWord, 3'd0, 32'h11C,
                  1, 7, MemWord, 32'h11C, 1, 32'd7, 0);
    applyStimulus("loadType6", 0, 0, 0, 1, 7, 1, 32'h2001, MemWord, 3'd6, 32'h120,
                  1, 7, MemWord, 32'h120, 1, 32'd8, 0);

    // Stall holds everything for three cycles, then the next M instruction enters
    applyStimulus("preStall", 0, 0, 0, 1, 9, 0, 32'hCAFEF00D, 32'h0, 0, 32'h124,
                  1, 9, 32'hCAFEF00D, 32'h124, 1, 32'd9, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stallHold", 0, 1, 0, 1, 10, 0, 32'hDEADBEEF, 32'h0, 0, 32'h128,
                    1, 9, 32'hCAFEF00D, 32'h124, 1, 32'd9, 0);
    end
    applyStimulus("stallRelease", 0, 0, 0, 1, 10, 0, 32'hDEADBEEF, 32'h0, 0, 32'h128,
                  1, 10, 32'hDEADBEEF, 32'h128, 1, 32'd10, 0);

    // Flush wins over stall; a stalled edge does not retire
    applyStimulus("flushStall", 0, 1, 1, 1, 12, 1, 32'h44, MemWord, 0, 32'h12C,
                  0, 0, 32'h0, 32'h0, 0, 32'd10, 0);
    applyStimulus("refill", 0, 0, 0, 1, 3, 0, 32'h5, 32'h0, 0, 32'h12C,
                  1, 3, 32'h5, 32'h12C, 1, 32'd10, 0);
    applyStimulus("flushRetire", 0, 0, 1, 1, 13, 0, 32'h66, 32'h0, 0, 32'h130,
                  0, 0, 32'h0, 32'h0, 0, 32'd11, 0);
    applyStimulus("afterBubble", 0, 0, 0, 1, 4, 0, 32'h7, 32'h0, 0, 32'h130,
                  1, 4, 32'h7, 32'h130, 1, 32'd11, 0);

    // Counter wrap from all-ones
    applyStimulus("retireWrap", 0, 0, 0, 1, 6, 0, 32'h9, 32'h0, 0, 32'h134,
                  1, 6, 32'h9, 32'h134, 1, 32'd0, 1);
    applyStimulus("postWrap", 0, 0, 0, 1, 8, 0, 32'hA, 32'h0, 0, 32'h138,
                  1, 8, 32'hA, 32'h138, 1, 32'd1, 0);

    // Reset discards the W instruction and beats stall and flush
    applyStimulus("midReset", 1, 0, 0, 1, 9, 0, $urandom, $urandom, 0, $urandom,
                  0, 0, 32'h0, 32'h0, 0, 32'd0, 0);
    applyStimulus("resetStall", 1, 1, 1, 1, 9, 0, $urandom, $urandom, 0, $urandom,
                  0, 0, 32'h0, 32'h0, 0, 32'd0, 0);
    applyStimulus("postReset", 0, 0, 0, 1, 11, 0, 32'h33, 32'h0, 0, 32'h140,
                  1, 11, 32'h33, 32'h140, 1, 32'd0, 0);
    applyStimulus("finalFlush", 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                  0, 0, 32'h0, 32'h0, 0, 32'd1, 0);

    // Let the monitor drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d responses never checked, want 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_w.md
PIPE_REG_W -- requirements
Module: pipe_reg_w

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL have these ports: reset, input, 1, synchronous active-high reset sampled on the clk rising edge.
REQ-003 The block SHALL have these ports: StallW, input, 1, hold all W-stage registers when high.
REQ-004 The block SHALL have these ports: FlushW, input, 1, load a bubble into the W stage when high.
REQ-005 The block SHALL have these ports: RegWriteM, input, 1, M-stage register-write enable.
REQ-006 The block SHALL have these ports: WriteRegM, input, 5, M-stage destination register.
REQ-007 The block SHALL have these ports: MemtoRegM, input, 1, select memory data over ALU result.
REQ-008 The block SHALL have these ports: ALUOutM, input, 32, M-stage ALU result and load address.
REQ-009 The block SHALL have these ports: ReadDataM, input, 32, raw word read from data memory.
REQ-010 The block SHALL have these ports: LoadTypeM, input, 3, load kind: 0 word, 1 lbu, 2 lb, 3 lhu, 4 lh; 5-7 are treated as word.
REQ-011 The block SHALL have these ports: PCM, input, 32, M-stage instruction PC.
REQ-012 The block SHALL have these ports: RegWriteW, output, 1, W-stage write enable to the register file and forwarding units.
REQ-013 The block SHALL have these ports: WriteRegW, output, 5, W-stage destination register.
REQ-014 The block SHALL have these ports: ResultW, output, 32, write-back data.
REQ-015 The block SHALL have these ports: PCW, output, 32, W-stage PC.
REQ-016 The block SHALL have these ports: ValidW, output, 1, W stage holds a real instruction.
REQ-017 The block SHALL have these ports: RetireCnt, output, 32, count of retired valid instructions.

Function
REQ-018 On each clk edge with reset=0, FlushW=0 and StallW=0, the W registers SHALL capture the M inputs and set ValidW=1, giving a latency of one cycle from M to W.
REQ-019 With StallW=1 and FlushW=0, all W registers and RetireCnt SHALL hold their values.
REQ-020 With FlushW=1, the W stage SHALL load a bubble (RegWriteW=0, WriteRegW=0, ResultW=0, PCW=0, ValidW=0) regardless of StallW, because flush has priority.
REQ-021 RegWriteW SHALL be registered as RegWriteM AND (WriteRegM!=0), so that register $0 is never reported as written.
REQ-022 ResultW SHALL equal the registered ALUOutM when the registered MemtoReg is 0, and the extended load data when it is 1.
REQ-023 Load extraction SHALL use the registered ALUOutM[1:0]: the byte is selected by [1:0] and the halfword by [1] (little-endian).
REQ-024 For lbu and lhu the extracted value SHALL be zero-extended, and for lb and lh it SHALL be sign-extended to 32 bits.
REQ-025 The extraction and multiplexing logic SHALL be combinational from the W registers, so ResultW is stable for the whole W cycle.
REQ-026 RetireCnt SHALL increment by 1 on every edge where ValidW=1 and StallW=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 The retirement of the current W instruction SHALL be counted on the same edge that a flush bubble is loaded.

Reset
REQ-028 When reset=1 at a clk edge, RegWriteW, WriteRegW, ResultW, PCW, ValidW and RetireCnt SHALL all become 0.
REQ-029 Reset SHALL take priority over FlushW and StallW.
REQ-030 An instruction in flight in the W stage when reset is asserted SHALL be discarded without being counted.

Configuration
REQ-031 When the macro PIPE_REG_W_SUBWORD_LOAD_EN is defined, the block SHALL implement the byte and halfword load extraction of REQ-023 and REQ-024.
REQ-032 When PIPE_REG_W_SUBWORD_LOAD_EN is not defined, LoadTypeM SHALL be ignored and memory data SHALL pass through as the raw word.

Verification
REQ-033 The bench SHALL cover: reset=1 for 2 cycles with random M inputs -> all outputs 0 and RetireCnt=0.
REQ-034 The bench SHALL cover: RegWriteM=1, WriteRegM=5, MemtoRegM=0, ALUOutM=0x12345678 -> next cycle RegWriteW=1, WriteRegW=5, ResultW=0x12345678, ValidW=1, and RetireCnt increments one cycle later.
REQ-035 The bench SHALL cover: RegWriteM=1, WriteRegM=0 -> RegWriteW=0 in W.
REQ-036 The bench SHALL cover, with the macro defined: ReadDataM=0x80F0A0B0, MemtoRegM=1, ALUOutM[1:0]=3 with lb -> ResultW=0xFFFFFF80; the same case with lbu -> 0x00000080; ALUOutM[1:0]=0 with lh -> 0xFFFFA0B0; with the macro undefined, lb -> 0x80F0A0B0.
REQ-037 The bench SHALL cover: a valid W instruction with StallW=1 for 3 cycles -> outputs and RetireCnt are unchanged throughout; then StallW=0 -> the next M instruction is captured.
REQ-038 The bench SHALL cover: StallW=1 and FlushW=1 together -> a bubble is loaded; and RetireCnt preset to 0xFFFFFFFF with a valid retire -> RetireCnt becomes 0.
